// File: rtl/cordic_vec_sequencer.sv
// cordic_vec_sequencer
//   Iterative vectoring CORDIC controller. It accepts one Q4.11 (X,Y) pair,
//   pre-rotates it into the right half-plane, and then drives Y towards zero
//   with ITER shift-add micro-rotations on a single shared stage. It returns
//   the magnitude (CORDIC gain included, saturated) and the angle atan2(Y,X)
//   in radians (Q4.11). Only one transaction is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input pair valid
//   in_ready   block can accept a pair (high only in IDLE)
//   x_in/y_in  signed Q4.11 input vector
//   out_valid  result valid (held in DONE until out_ready)
//   out_ready  consumer accepts the result
//   mag_out    K*sqrt(X^2+Y^2), Q4.11, saturated to WIDTH bits
//   ang_out    atan2(Y,X), Q4.11 radians
//   busy       high in any state other than IDLE
module cordic_vec_sequencer #(
    parameter int WIDTH = 16,
    parameter int ITER  = 12,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag_out,
    output logic signed [WIDTH-1:0] ang_out,
    output logic                    busy
);

    localparam int IW = WIDTH + GUARD;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0]          CNT_END = 4'(ITER);
    localparam logic signed [IW-1:0] HALF_PI = IW'(3217);
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (WIDTH - 1)));

    // atan(2^-i) in Q4.11, rounded
    function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return IW'(1608);
            4'd1:    return IW'(950);
            4'd2:    return IW'(502);
            4'd3:    return IW'(255);
            4'd4:    return IW'(128);
            4'd5:    return IW'(64);
            4'd6:    return IW'(32);
            4'd7:    return IW'(16);
            4'd8:    return IW'(8);
            4'd9:    return IW'(4);
            4'd10:   return IW'(2);
            4'd11:   return IW'(1);
            4'd12:   return IW'(1);
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [IW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic signed [IW-1:0]    x_q, x_d;
    logic signed [IW-1:0]    y_q, y_d;
    logic signed [IW-1:0]    z_q, z_d;
    logic                    zero_q, zero_d;
    logic                    vld_q, vld_d;
    logic signed [WIDTH-1:0] mag_q, mag_d;
    logic signed [WIDTH-1:0] ang_q, ang_d;

    logic signed [IW-1:0] xs, ys;

    assign xs = x_q >>> cnt_q;
    assign ys = y_q >>> cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        vld_d   = vld_q;
        mag_d   = mag_q;
        ang_d   = ang_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = {{GUARD{x_in[WIDTH-1]}}, x_in};
                    y_d     = {{GUARD{y_in[WIDTH-1]}}, y_in};
                    z_d     = '0;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                // Negations happen at IW bits so -(-2^(WIDTH-1)) does not wrap.
                zero_d = 1'b0;
                if (x_q == '0 && y_q == '0) begin
                    // The zero vector has no angle; freeze Z at 0 so the
                    // micro-rotations do not accumulate the LUT into it.
                    zero_d = 1'b1;
                    x_d    = '0;
                    y_d    = '0;
                    z_d    = '0;
                end else if (!x_q[IW-1]) begin
                    z_d = '0;
                end else if (!y_q[IW-1]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = HALF_PI;
                end else begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -HALF_PI;
                end
                cnt_d   = '0;
                state_d = S_ITER;
            end

            S_ITER: begin
                if (cnt_q == CNT_END) begin
                    // Finalize cycle after the last micro-rotation: register
                    // the results and present them in DONE.
                    mag_d   = sat_w(x_q);
                    ang_d   = z_q[WIDTH-1:0];
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (!zero_q) begin
                        if (y_q[IW-1]) begin
                            x_d = x_q - ys;
                            y_d = y_q + xs;
                            z_d = z_q - atan_lut(cnt_q);
                        end else begin
                            x_d = x_q + ys;
                            y_d = y_q - xs;
                            z_d = z_q + atan_lut(cnt_q);
                        end
                    end
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = vld_q;
    assign mag_out   = mag_q;
    assign ang_out   = ang_q;

endmodule
